// File: rtl/qlf_k6n10f_pl_pkg.sv
// Shared widths, FSM encoding and readback helper for the TDP36K PL-port loader.
package qlf_k6n10f_pl_pkg;

  localparam int unsigned PL_ADDR_W = 24;
  localparam int unsigned PL_DATA_W = 36;
  localparam int unsigned PL_HALF_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD_SETUP,
    LOAD_STROBE,
    RB_SETUP,
    RB_STROBE,
    RB_WAIT,
    DONE
  } pl_state_t;

  // Readback compare restricted to the halves that were actually written.
  function automatic logic half_mismatch(input logic [PL_DATA_W-1:0] wr,
                                         input logic [PL_DATA_W-1:0] rd,
                                         input logic [1:0]           be);
    logic lo_bad;
    logic hi_bad;
    lo_bad = be[0] && (wr[PL_HALF_W-1:0] != rd[PL_HALF_W-1:0]);
    hi_bad = be[1] && (wr[PL_DATA_W-1:PL_HALF_W] != rd[PL_DATA_W-1:PL_HALF_W]);
    return lo_bad || hi_bad;
  endfunction

endpackage

// File: rtl/qlf_k6n10f_bram_pl_loader.sv
// Streams fabric words into one TDP36K through its PL preload port.
// Define BRAM_PL_VERIFY_EN to read back and compare every written word.
module qlf_k6n10f_bram_pl_loader
  import qlf_k6n10f_pl_pkg::*;
#(
  parameter int unsigned ADDR_W      = PL_ADDR_W,
  parameter int unsigned DATA_W      = PL_DATA_W,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [1:0]        s_be_i,
  output logic              s_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              pl_init_o,
  output logic              pl_ena_o,
  output logic [1:0]        pl_wen_o,
  output logic              pl_ren_o,
  output logic              pl_clk_o,
  output logic [ADDR_W-1:0] pl_addr_o,
  output logic [DATA_W-1:0] pl_data_o,
  input  logic [DATA_W-1:0] pl_data_i
);

  localparam int unsigned DLY_MAX = (INIT_CYCLES > RD_LAT) ? INIT_CYCLES : RD_LAT;
  localparam int unsigned DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

  pl_state_t         state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DLY_W-1:0]  dly_q;

`ifdef BRAM_PL_VERIFY_EN
  logic       err_q;
  logic [1:0] be_q;
  assign err_o = err_q;
`else
  logic unused_pl_data;
  assign err_o          = 1'b0;
  assign unused_pl_data = ^pl_data_i;
`endif

  // Outputs are registered one step ahead of the state they belong to, so the
  // PL address/data/wen settle a full clk before every pl_clk_o rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      dly_q     <= '0;
      s_ready_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pl_init_o <= 1'b0;
      pl_ena_o  <= 1'b0;
      pl_wen_o  <= '0;
      pl_ren_o  <= 1'b0;
      pl_clk_o  <= 1'b0;
      pl_addr_o <= '0;
      pl_data_o <= '0;
`ifdef BRAM_PL_VERIFY_EN
      err_q     <= 1'b0;
      be_q      <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (word_count_i != '0) begin
              base_q    <= base_addr_i;
              count_q   <= word_count_i;
              idx_q     <= '0;
              dly_q     <= DLY_W'(INIT_CYCLES - 1);
              busy_o    <= 1'b1;
              pl_init_o <= 1'b1;
              pl_ena_o  <= 1'b1;
`ifdef BRAM_PL_VERIFY_EN
              err_q     <= 1'b0;
`endif
              state     <= INIT;
            end else begin
              done_o <= 1'b1;
            end
          end
        end

        INIT: begin
          if (dly_q == '0) begin
            pl_init_o <= 1'b0;
            s_ready_o <= 1'b1;
            state     <= LOAD_SETUP;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end

        LOAD_SETUP: begin
          pl_clk_o <= 1'b0;
          if (s_valid_i && s_ready_o) begin
            pl_addr_o <= base_q + ADDR_W'(idx_q);
            pl_data_o <= s_data_i;
            pl_wen_o  <= s_be_i;
`ifdef BRAM_PL_VERIFY_EN
            be_q      <= s_be_i;
`endif
            s_ready_o <= 1'b0;
            state     <= LOAD_STROBE;
          end
        end

        LOAD_STROBE: begin
          pl_clk_o <= 1'b1;
          idx_q    <= idx_q + CNT_W'(1);
`ifdef BRAM_PL_VERIFY_EN
          state    <= RB_SETUP;
`else
          if (idx_q + CNT_W'(1) == count_q) begin
            state <= DONE;
          end else begin
            s_ready_o <= 1'b1;
            state     <= LOAD_SETUP;
          end
`endif
        end

`ifdef BRAM_PL_VERIFY_EN
        RB_SETUP: begin
          pl_clk_o <= 1'b0;
          pl_wen_o <= '0;
          pl_ren_o <= 1'b1;
          state    <= RB_STROBE;
        end

        RB_STROBE: begin
          pl_clk_o <= 1'b1;
          dly_q    <= DLY_W'(RD_LAT - 1);
          state    <= RB_WAIT;
        end

        RB_WAIT: begin
          pl_clk_o <= 1'b0;
          if (dly_q == '0) begin
            if (half_mismatch(PL_DATA_W'(pl_data_o), PL_DATA_W'(pl_data_i), be_q)) begin
              err_q <= 1'b1;
            end
            pl_ren_o <= 1'b0;
            if (idx_q == count_q) begin
              state <= DONE;
            end else begin
              s_ready_o <= 1'b1;
              state     <= LOAD_SETUP;
            end
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end
`endif

        DONE: begin
          pl_clk_o  <= 1'b0;
          pl_init_o <= 1'b0;
          pl_ena_o  <= 1'b0;
          pl_wen_o  <= '0;
          pl_ren_o  <= 1'b0;
          pl_addr_o <= '0;
          pl_data_o <= '0;
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
